// File: rtl/bsg_cgol_pkg.sv
// Shared definitions for the Game-of-Life input path and controller.
// Holds the input-deserializer state encoding and the width/beat-count
// helper functions, so every block sizes the frame count the same way.
package bsg_cgol_pkg;

    typedef enum logic [1:0] {
        HEADER = 2'd0,
        LOAD   = 2'd1,
        FULL   = 2'd2
    } deser_state_e;

    // Like $clog2, but never returns 0, so a one-value counter still gets 1 bit.
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // The frame count must hold every value from 0 to max_game_length inclusive.
    function automatic int game_len_width(input int max_game_length);
        return safe_clog2(max_game_length + 1);
    endfunction

endpackage

// File: rtl/bsg_cgol_beat_counter.sv
// Purpose: beat index for the board load. Supports a clear and an increment, and flags the final beat.
// Latency: count_o changes on the edge after clear_i or incr_i; last_o is a pure decode of count_o.
// Backpressure: none. The caller asserts incr_i only on an accepted beat.
// Ports: clk_i/reset_i (async, active-high), clear_i, incr_i -> count_o, last_o.
module bsg_cgol_beat_counter
    import bsg_cgol_pkg::*;
#(
    parameter  int max_val_p = 2,
    localparam int width_lp  = safe_clog2(max_val_p)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                clear_i,
    input  logic                incr_i,
    output logic [width_lp-1:0] count_o,
    output logic                last_o
);

    localparam logic [width_lp-1:0] last_val_lp = width_lp'(max_val_p - 1);

    logic [width_lp-1:0] count_q;
    logic [width_lp-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (incr_i) begin
            count_d = count_q + width_lp'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == last_val_lp);

endmodule

// File: rtl/bsg_cgol_input_deser.sv
// Purpose: collects one header word (the frame count) and a row-major board from a narrow stream.
//          It then presents the board and frame count together to the controller.
// Latency: v_o rises the cycle after the last board beat. ready_o returns one cycle after the output handshake.
// Backpressure: ready_o is low while a board is held. Outputs stay stable until ready_i accepts them.
// Ports: clk_i, reset_i (async, active-high); v_i/data_i/ready_o input stream;
//        v_o/frames_o/data_o/ready_i output handshake. data_o bit r*board_width_p+c is cell (r,c).
module bsg_cgol_input_deser
    import bsg_cgol_pkg::*;
#(
    parameter  int board_width_p     = 32,
    parameter  int max_game_length_p = 1024,
    parameter  int data_width_p      = 64,
    localparam int game_len_width_lp = game_len_width(max_game_length_p),
    localparam int board_bits_lp     = board_width_p * board_width_p
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         v_i,
    input  logic [data_width_p-1:0]      data_i,
    output logic                         ready_o,
    output logic                         v_o,
    output logic [game_len_width_lp-1:0] frames_o,
    output logic [board_bits_lp-1:0]     data_o,
    input  logic                         ready_i
);

    localparam int beats_lp     = ceil_div(board_bits_lp, data_width_p);
    localparam int cnt_width_lp = safe_clog2(beats_lp);

    deser_state_e                 state_q, state_d;
    logic [game_len_width_lp-1:0] frames_q, frames_d;
    logic [board_bits_lp-1:0]     board_q, board_d;

    logic [cnt_width_lp-1:0] beat_cnt;
    logic                    beat_last;
    logic                    cnt_clear;
    logic                    cnt_incr;
    logic                    in_xfer;
    logic                    out_xfer;

    // Outputs decode state only, so there is no combinational path from ready_i or v_i.
    assign ready_o  = (state_q != FULL);
    assign v_o      = (state_q == FULL);
    assign frames_o = frames_q;
    assign data_o   = board_q;

    assign in_xfer  = v_i & ready_o;
    assign out_xfer = v_o & ready_i;

    bsg_cgol_beat_counter #(
        .max_val_p (beats_lp)
    ) beat_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (cnt_clear),
        .incr_i  (cnt_incr),
        .count_o (beat_cnt),
        .last_o  (beat_last)
    );

    always_comb begin
        state_d   = state_q;
        frames_d  = frames_q;
        board_d   = board_q;
        cnt_clear = 1'b0;
        cnt_incr  = 1'b0;
        unique case (state_q)
            HEADER: begin
                if (in_xfer) begin
                    // Upper header bits above the frame-count width are ignored.
                    frames_d  = data_i[game_len_width_lp-1:0];
                    cnt_clear = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (in_xfer) begin
                    // Per-bit write: the final beat may extend past the board.
                    // Bits beyond the last cell are dropped, not wrapped.
                    for (int i = 0; i < data_width_p; i++) begin
                        if (int'(beat_cnt) * data_width_p + i < board_bits_lp) begin
                            board_d[int'(beat_cnt) * data_width_p + i] = data_i[i];
                        end
                    end
                    if (beat_last) begin
                        state_d = FULL;
                    end else begin
                        cnt_incr = 1'b1;
                    end
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_d = HEADER;
                end
            end
            default: state_d = HEADER;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= HEADER;
            frames_q <= '0;
            board_q  <= '0;
        end else begin
            state_q  <= state_d;
            frames_q <= frames_d;
            board_q  <= board_d;
        end
    end

endmodule

// File: tb/tb_bsg_cgol_input_deser.sv
module tb_bsg_cgol_input_deser;

    logic        clk_i;
    logic        reset_i;
    logic        v_i;
    logic [7:0]  data_i;
    logic        ready_o;
    logic        v_o;
    logic [3:0]  frames_o;
    logic [15:0] data_o;
    logic        ready_i;

    int tests;
    int fails;

    bsg_cgol_input_deser #(
        .board_width_p     (4),
        .max_game_length_p (15),
        .data_width_p      (8)
    ) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .v_i      (v_i),
        .data_i   (data_i),
        .ready_o  (ready_o),
        .v_o      (v_o),
        .frames_o (frames_o),
        .data_o   (data_o),
        .ready_i  (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        r;
        logic        ev;
        logic        er;
        logic [3:0]  ef;
        logic [15:0] ed;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic er,
                             input logic [3:0] ef, input logic [15:0] ed);
        check({tag, " v_o"}, 64'(v_o), 64'(ev));
        check({tag, " ready_o"}, 64'(ready_o), 64'(er));
        check({tag, " frames_o"}, 64'(frames_o), 64'(ef));
        check({tag, " data_o"}, 64'(data_o), 64'(ed));
    endtask

    // Drive one cycle's inputs mid-cycle, then sample just after the rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        @(negedge clk_i);
        v_i     = v;
        data_i  = d;
        ready_i = r;
        @(posedge clk_i);
        #1;
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic r, input logic ev,
                       input logic er, input logic [3:0] ef, input logic [15:0] ed);
        vec_t x;
        x = '{v, d, r, ev, er, ef, ed};
        vecs.push_back(x);
    endtask

    logic [7:0]  wq[$];
    logic [3:0]  exp_f[$];
    logic [15:0] exp_d[$];

    initial begin
        tests   = 0;
        fails   = 0;
        reset_i = 1'b1;
        v_i     = 1'b0;
        data_i  = 8'h00;
        ready_i = 1'b0;

        // Expected outputs after each edge (columns: v d r | v_o ready_o frames data).
        // Game 1: load, then hold under backpressure while v_i stays high.
        add(1, 8'h0A, 0,  0, 1, 4'hA, 16'h0000);
        add(1, 8'h3C, 0,  0, 1, 4'hA, 16'h003C);
        add(1, 8'hA5, 0,  1, 0, 4'hA, 16'hA53C);
        for (int i = 0; i < 5; i++) add(1, 8'hFF, 0, 1, 0, 4'hA, 16'hA53C);
        add(1, 8'hFF, 1,  0, 1, 4'hA, 16'hA53C);
        // Game 2: header upper bits ignored, then idle cycles.
        add(1, 8'hF7, 0,  0, 1, 4'h7, 16'hA53C);
        add(1, 8'h12, 0,  0, 1, 4'h7, 16'hA512);
        add(1, 8'h34, 0,  1, 0, 4'h7, 16'h3412);
        add(0, 8'h00, 1,  0, 1, 4'h7, 16'h3412);
        add(0, 8'h00, 0,  0, 1, 4'h7, 16'h3412);
        // Back-to-back games: 09 is held across the handshake edge and is accepted one cycle later.
        add(1, 8'h05, 1,  0, 1, 4'h5, 16'h3412);
        add(1, 8'h11, 1,  0, 1, 4'h5, 16'h3411);
        add(1, 8'h22, 1,  1, 0, 4'h5, 16'h2211);
        add(1, 8'h09, 1,  0, 1, 4'h5, 16'h2211);
        add(1, 8'h09, 1,  0, 1, 4'h9, 16'h2211);
        add(1, 8'h33, 1,  0, 1, 4'h9, 16'h2233);
        add(1, 8'h44, 1,  1, 0, 4'h9, 16'h4433);
        add(0, 8'h00, 1,  0, 1, 4'h9, 16'h4433);

        #3;
        check_all("reset held", 0, 1, 4'h0, 16'h0000);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_all("after release", 0, 1, 4'h0, 16'h0000);

        foreach (vecs[k]) begin
            step(vecs[k].v, vecs[k].d, vecs[k].r);
            check_all($sformatf("vec%0d", k), vecs[k].ev, vecs[k].er, vecs[k].ef, vecs[k].ed);
        end

        // Asynchronous reset in the middle of LOAD.
        step(1, 8'h06, 0);
        step(1, 8'h77, 0);
        #2 reset_i = 1'b1;
        #1;
        check_all("reset mid-load", 0, 1, 4'h0, 16'h0000);
        @(negedge clk_i);
        reset_i = 1'b0;
        v_i     = 1'b0;

        // Asynchronous reset while a board is held: v_o must drop before any edge.
        step(1, 8'h0C, 0);
        step(1, 8'hAB, 0);
        step(1, 8'hCD, 0);
        check("full before reset v_o", 64'(v_o), 64'd1);
        #2 reset_i = 1'b1;
        #1;
        check_all("reset in full", 0, 1, 4'h0, 16'h0000);
        @(negedge clk_i);
        reset_i = 1'b0;
        v_i     = 1'b0;

        step(1, 8'h03, 0);
        step(1, 8'h01, 0);
        step(1, 8'h80, 0);
        check_all("post-reset game", 1, 0, 4'h3, 16'h8001);
        step(0, 8'h00, 1);
        check_all("post-reset drain", 0, 1, 4'h3, 16'h8001);

        // Random gaps on both sides against a scoreboard.
        for (int g = 0; g < 100; g++) begin
            logic [7:0] h, b0, b1;
            h  = 8'($urandom_range(0, 255));
            b0 = 8'($urandom_range(0, 255));
            b1 = 8'($urandom_range(0, 255));
            wq.push_back(h);
            wq.push_back(b0);
            wq.push_back(b1);
            exp_f.push_back(h[3:0]);
            exp_d.push_back({b1, b0});
        end
        begin
            int wptr;
            int got;
            int cyc;
            logic in_x;
            wptr = 0;
            got  = 0;
            cyc  = 0;
            while (got < 100 && cyc < 20000) begin
                @(negedge clk_i);
                if (wptr < wq.size() && $urandom_range(0, 3) != 0) begin
                    v_i    = 1'b1;
                    data_i = wq[wptr];
                end else begin
                    v_i    = 1'b0;
                    data_i = 8'($urandom_range(0, 255));
                end
                ready_i = ($urandom_range(0, 2) != 0);
                #1;
                in_x = v_i & ready_o;
                if (v_o && ready_i) begin
                    check($sformatf("rand game%0d frames", got), 64'(frames_o), 64'(exp_f[got]));
                    check($sformatf("rand game%0d board", got), 64'(data_o), 64'(exp_d[got]));
                    got++;
                end
                @(posedge clk_i);
                if (in_x) wptr++;
                cyc++;
            end
            check("rand games delivered", 64'(got), 64'd100);
            check("rand words consumed", 64'(wptr), 64'(wq.size()));
            step(0, 8'h00, 1);
            step(0, 8'h00, 1);
            check("rand no extra game", 64'(v_o), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
